// File: rtl/trace_frame_rx.sv
// Host-side receiver for the capture board's UART dump: issues one command byte,
// then reassembles plaintext/key/ciphertext words and streams sensor samples out.
module trace_frame_rx #(
    parameter int         SAMPLES = 2048,
    parameter int         ADDRW   = 11,
    parameter int         TIMEOUT = 1000000,
    parameter int         TOW     = 20,
    parameter logic [7:0] MARKER  = 8'd255
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_byte,
    output logic             cmd_ready,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    input  logic             tx_done,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte,
    output logic [127:0]     pt,
    output logic [127:0]     key,
    output logic [127:0]     ct,
    output logic             samp_we,
    output logic [ADDRW-1:0] samp_addr,
    output logic [7:0]       samp_data,
    output logic [ADDRW-1:0] mark_idx,
    output logic             mark_found,
    output logic             frame_done,
    output logic             timeout_err,
    output logic             cmd_err,
    output logic [2:0]       state_dbg
);

    // Handshake: a command is taken on any clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so commands offered elsewhere are dropped.
    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_TX, RX_PT, RX_KEY, RX_CT, RX_SAMP, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [11:0]      cnt;
    logic [11:0]      samp_idx;
    logic [TOW-1:0]   to_cnt;
    logic             cmd_ok;
    logic             in_rx;
    logic             to_hit;
    logic             last_samp;

    assign cmd_ok    = (cmd_byte == 8'd250) || (cmd_byte <= 8'd31);
    assign in_rx     = (state == RX_PT) || (state == RX_KEY) || (state == RX_CT) || (state == RX_SAMP);
    // A byte arriving on the terminal count cycle wins over the timeout.
    assign to_hit    = in_rx && !rx_dv && (to_cnt == TOW'(TIMEOUT - 1));
    assign samp_idx  = cnt - 12'd48;
    assign last_samp = (state == RX_SAMP) && rx_dv && (samp_idx == 12'(SAMPLES - 1));

    assign cmd_ready  = (state == IDLE);
    assign tx_dv      = (state == SEND);
    assign frame_done = (state == DONE);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ok) state_nxt = SEND;
            SEND:    state_nxt = WAIT_TX;
            WAIT_TX: if (tx_done) state_nxt = RX_PT;
            RX_PT:   if (rx_dv && cnt[3:0] == 4'hF) state_nxt = RX_KEY;
            RX_KEY:  if (rx_dv && cnt[3:0] == 4'hF) state_nxt = RX_CT;
            RX_CT:   if (rx_dv && cnt[3:0] == 4'hF) state_nxt = RX_SAMP;
            RX_SAMP: if (last_samp) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (to_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_byte     <= 8'd0;
            pt          <= '0;
            key         <= '0;
            ct          <= '0;
            samp_we     <= 1'b0;
            samp_addr   <= '0;
            samp_data   <= 8'd0;
            mark_idx    <= '0;
            mark_found  <= 1'b0;
            timeout_err <= 1'b0;
            cmd_err     <= 1'b0;
            cnt         <= 12'd0;
            to_cnt      <= '0;
        end else begin
            cmd_err <= 1'b0;
            samp_we <= 1'b0;

            if (state == IDLE && cmd_valid) begin
                if (cmd_ok) begin
                    tx_byte     <= cmd_byte;
                    timeout_err <= 1'b0;
                    mark_found  <= 1'b0;
                    mark_idx    <= '0;
                    cnt         <= 12'd0;
                end else begin
                    cmd_err <= 1'b1;
                end
            end

            if (state == WAIT_TX) to_cnt <= '0;

            // Saturating inter-byte timer; it never wraps back to zero.
            if (in_rx) begin
                if (rx_dv)                                to_cnt <= '0;
                else if (to_cnt != TOW'(TIMEOUT - 1))     to_cnt <= to_cnt + 1'b1;
            end

            if (to_hit) timeout_err <= 1'b1;

            if (in_rx && rx_dv) begin
                cnt <= cnt + 12'd1;
                case (state)
                    RX_PT:  pt  <= {pt[119:0], rx_byte};
                    RX_KEY: key <= {key[119:0], rx_byte};
                    RX_CT:  ct  <= {ct[119:0], rx_byte};
                    RX_SAMP: begin
                        samp_we   <= 1'b1;
                        samp_addr <= samp_idx[ADDRW-1:0];
                        samp_data <= rx_byte;
                        if (rx_byte == MARKER && !mark_found) begin
                            mark_found <= 1'b1;
                            mark_idx   <= samp_idx[ADDRW-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_frame_rx.sv
// Self-checking bench for trace_frame_rx: random frames checked against a
// byte-level reference model of the dump format.
module tb_trace_frame_rx;
    localparam int         SAMPLES = 2048;
    localparam int         ADDRW   = 11;
    localparam int         TIMEOUT = 300;
    localparam int         TOW     = 20;
    localparam logic [7:0] MARKER  = 8'd255;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [7:0]       cmd_byte = 8'd0;
    logic             cmd_ready;
    logic             tx_dv;
    logic [7:0]       tx_byte;
    logic             tx_done = 1'b0;
    logic             rx_dv = 1'b0;
    logic [7:0]       rx_byte = 8'd0;
    logic [127:0]     pt, key, ct;
    logic             samp_we;
    logic [ADDRW-1:0] samp_addr;
    logic [7:0]       samp_data;
    logic [ADDRW-1:0] mark_idx;
    logic             mark_found;
    logic             frame_done;
    logic             timeout_err;
    logic             cmd_err;
    logic [2:0]       state_dbg;

    trace_frame_rx #(
        .SAMPLES(SAMPLES), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT), .TOW(TOW), .MARKER(MARKER)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
        .rx_dv(rx_dv), .rx_byte(rx_byte),
        .pt(pt), .key(key), .ct(ct),
        .samp_we(samp_we), .samp_addr(samp_addr), .samp_data(samp_data),
        .mark_idx(mark_idx), .mark_found(mark_found),
        .frame_done(frame_done), .timeout_err(timeout_err), .cmd_err(cmd_err),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Output monitor: counts strobes and captures the sample write stream.
    int               tx_cnt = 0;
    int               fd_cnt = 0;
    int               ce_cnt = 0;
    logic [7:0]       last_tx = 8'd0;
    logic [ADDRW-1:0] obs_addr_q[$];
    logic [7:0]       obs_data_q[$];
    logic [7:0]       exp_q[$];

    always @(negedge clk) begin
        if (samp_we) begin
            obs_addr_q.push_back(samp_addr);
            obs_data_q.push_back(samp_data);
        end
        if (tx_dv) begin
            tx_cnt++;
            last_tx = tx_byte;
        end
        if (frame_done) fd_cnt++;
        if (cmd_err)    ce_cnt++;
    end

    // Driver tasks (all entered and left on a falling edge)
    task automatic send_cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_byte  = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic serve_tx(input int strays, output bit seen);
        int n;
        n = 0;
        while (!tx_dv && n < 50) begin
            @(negedge clk);
            n++;
        end
        seen = tx_dv;
        @(negedge clk);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        for (int i = 0; i < strays; i++) send_byte(8'($urandom));
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full frame scenario. mode 0: fixed pattern with marker at 700;
    // 1: random bytes; 2: random with no marker; 3: no marker except indexes 5 and 9.
    task automatic test_frame(input logic [7:0] cmd, input int mode, input int strays, input string name);
        logic [127:0] e_pt, e_key, e_ct;
        logic [7:0]   s;
        bit           e_found, seen;
        int           e_idx, tx0, fd0, n, bad, first_bad;
        exp_q.delete();
        if (mode == 0) begin
            e_pt  = 128'h000102030405060708090a0b0c0d0e0f;
            e_key = 128'h000102030405060708090a0b0c0d0ef0;
            e_ct  = {16{8'hAA}};
        end else begin
            e_pt  = rand128();
            e_key = rand128();
            e_ct  = rand128();
        end
        for (int i = 0; i < SAMPLES; i++) begin
            case (mode)
                0: begin
                    // i&FF would already hit 255 at 255, 511; keep those off the marker.
                    s = 8'(i);
                    if (s == MARKER) s = 8'hFE;
                    if (i == 700) s = MARKER;
                end
                1: s = 8'($urandom);
                default: s = 8'($urandom_range(0, 254));
            endcase
            if (mode == 3 && (i == 5 || i == 9)) s = MARKER;
            exp_q.push_back(s);
        end
        e_found = 1'b0;
        e_idx   = 0;
        for (int i = 0; i < SAMPLES; i++)
            if (!e_found && exp_q[i] == MARKER) begin
                e_found = 1'b1;
                e_idx   = i;
            end

        obs_addr_q.delete();
        obs_data_q.delete();
        tx0 = tx_cnt;
        fd0 = fd_cnt;
        for (int i = 0; i < strays; i++) send_byte(8'($urandom));
        send_cmd(cmd);
        serve_tx(strays, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s tx_dv: not seen within 50 cycles", name);
        end
        vectors++;
        if (tx_cnt !== tx0 + 1 || last_tx !== cmd) begin
            miscompares++;
            $display("FAIL %s tx: %0d strobes byte %0d, required 1 strobe byte %0d", name, tx_cnt - tx0, last_tx, cmd);
        end
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s timeout_err after cmd: %b, required 0", name, timeout_err);
        end

        for (int i = 0; i < 16; i++) send_byte(e_pt[127 - 8*i -: 8]);
        for (int i = 0; i < 16; i++) send_byte(e_key[127 - 8*i -: 8]);
        for (int i = 0; i < 16; i++) send_byte(e_ct[127 - 8*i -: 8]);
        for (int i = 0; i < SAMPLES; i++) send_byte(exp_q[i]);
        n = 0;
        while (fd_cnt == fd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);

        vectors++;
        if (fd_cnt !== fd0 + 1) begin
            miscompares++;
            $display("FAIL %s frame_done: %0d pulses, required 1", name, fd_cnt - fd0);
        end
        vectors++;
        if (pt !== e_pt) begin
            miscompares++;
            $display("FAIL %s pt: %h, required %h", name, pt, e_pt);
        end
        vectors++;
        if (key !== e_key) begin
            miscompares++;
            $display("FAIL %s key: %h, required %h", name, key, e_key);
        end
        vectors++;
        if (ct !== e_ct) begin
            miscompares++;
            $display("FAIL %s ct: %h, required %h", name, ct, e_ct);
        end
        vectors++;
        if (obs_data_q.size() !== SAMPLES) begin
            miscompares++;
            $display("FAIL %s samp_we count: %0d, required %0d", name, obs_data_q.size(), SAMPLES);
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < obs_data_q.size() && i < SAMPLES; i++)
            if (obs_addr_q[i] !== ADDRW'(i) || obs_data_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s samp stream: %0d bad writes, first #%0d addr %0d data %0d, required addr %0d data %0d",
                     name, bad, first_bad, obs_addr_q[first_bad], obs_data_q[first_bad], first_bad, exp_q[first_bad]);
        end
        vectors++;
        if (mark_found !== e_found || mark_idx !== ADDRW'(e_idx)) begin
            miscompares++;
            $display("FAIL %s mark: found %b idx %0d, required found %b idx %0d", name, mark_found, mark_idx, e_found, e_idx);
        end
        vectors++;
        if (cmd_ready !== 1'b1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end state: cmd_ready %b timeout_err %b, required 1 0", name, cmd_ready, timeout_err);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pt, key, ct} !== '0) begin
            miscompares++;
            $display("FAIL reset words: pt %h key %h ct %h, required 0", pt, key, ct);
        end
        vectors++;
        if ({samp_we, samp_addr, samp_data, mark_found, mark_idx, tx_dv, tx_byte, frame_done, timeout_err, cmd_err} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: we %b addr %0d data %0d mf %b mi %0d txdv %b txb %0d fd %b to %b ce %b, required all 0",
                     samp_we, samp_addr, samp_data, mark_found, mark_idx, tx_dv, tx_byte, frame_done, timeout_err, cmd_err);
        end
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset cmd_ready: %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] bad_cmds[5] = '{8'd40, 8'd32, 8'd249, 8'd251, 8'd255};
        int ce0, tx0;
        foreach (bad_cmds[i]) begin
            ce0 = ce_cnt;
            tx0 = tx_cnt;
            send_cmd(bad_cmds[i]);
            repeat (3) @(negedge clk);
            vectors++;
            if (ce_cnt !== ce0 + 1 || tx_cnt !== tx0 || cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_cmd %0d: cmd_err pulses %0d tx_dv %0d cmd_ready %b, required 1 0 1",
                         bad_cmds[i], ce_cnt - ce0, tx_cnt - tx0, cmd_ready);
            end
        end
    endtask

    task automatic test_timeout();
        logic [127:0] e_pt;
        bit           seen;
        int           n, fd0;
        e_pt = rand128();
        fd0  = fd_cnt;
        obs_data_q.delete();
        obs_addr_q.delete();
        send_cmd(8'd31);
        serve_tx(0, seen);
        for (int i = 0; i < 30; i++) begin
            rx_dv   = 1'b1;
            rx_byte = (i < 16) ? e_pt[127 - 8*i -: 8] : 8'($urandom);
            @(negedge clk);
            rx_dv = 1'b0;
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (timeout_err !== 1'b1 || n < TIMEOUT - 2 || n > TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout: err %b after %0d idle cycles, required 1 after about %0d", timeout_err, n, TIMEOUT);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || fd_cnt !== fd0 || obs_data_q.size() !== 0) begin
            miscompares++;
            $display("FAIL timeout state: cmd_ready %b frame_done %0d writes %0d, required 1 0 0",
                     cmd_ready, fd_cnt - fd0, obs_data_q.size());
        end
        vectors++;
        if (pt !== e_pt || timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout partial: pt %h err %b, required pt %h err 1", pt, timeout_err, e_pt);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        int fd0;
        fd0 = fd_cnt;
        send_cmd(8'd250);
        serve_tx(0, seen);
        for (int i = 0; i < 48; i++) send_byte(8'($urandom));
        for (int i = 0; i < 1000; i++) send_byte((i == 3) ? MARKER : 8'($urandom_range(0, 254)));
        rx_dv   = 1'b1;
        rx_byte = 8'($urandom);
        #1 rstn = 1'b0;
        #1;
        vectors++;
        if ({pt, key, ct} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset words: pt %h key %h ct %h, required 0", pt, key, ct);
        end
        vectors++;
        if ({samp_we, samp_addr, samp_data, mark_found, mark_idx, tx_dv, tx_byte, frame_done, timeout_err, cmd_err} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset outputs: we %b addr %0d data %0d mf %b mi %0d txdv %b txb %0d fd %b to %b ce %b, required all 0",
                     samp_we, samp_addr, samp_data, mark_found, mark_idx, tx_dv, tx_byte, frame_done, timeout_err, cmd_err);
        end
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (fd_cnt !== fd0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset after: frame_done %0d cmd_ready %b, required 0 1", fd_cnt - fd0, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'd250, 0, 0, "plan_frame");
        test_frame(8'd17, 1, 0, "cmd17_frame");
        test_bad_cmd();
        test_timeout();
        test_frame(8'd250, 2, 0, "no_marker");
        test_frame(8'd5, 3, 0, "marker_5_9");
        test_reset_mid_frame();
        test_frame(8'd250, 1, 0, "post_reset");
        test_frame(8'd0, 1, 3, "stray_bytes");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_frame_rx.md
Name: trace_frame_rx

Overview:
- Host-side counterpart of the sensor/AES capture board's UART protocol.
- Issues one command byte to `uart_tx`: 250 = run and increment the delay, 0..31 = set the delay and run.
- Then consumes the returned dump from `uart_rx` in this order: 16 plaintext bytes, 16 key bytes, 16 ciphertext bytes, SAMPLES sensor bytes.
- Reassembles the 128-bit words, streams samples to an external RAM write port, and reports the first sample index that carries the AES-done marker.
- Used in the loopback/second-board test rig.

Parameters:
- SAMPLES, 2048, number of sensor bytes per frame.
- ADDRW, 11, sample address width; 2**ADDRW >= SAMPLES.
- TIMEOUT, 1000000, inter-byte timeout in clk cycles while receiving.
- TOW, 20, timeout counter width.
- MARKER, 8'd255, sample value flagging AES done.

Ports:
- clk  in  1  system clock (same clock as uart_tx/uart_rx).
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_byte  in  8  command value.
- cmd_ready  out  1  high only in IDLE.
- tx_dv  out  1  one-cycle strobe to uart_tx.
- tx_byte  out  8  byte to uart_tx.
- tx_done  in  1  uart_tx done pulse.
- rx_dv  in  1  uart_rx byte-valid pulse.
- rx_byte  in  8  uart_rx byte.
- pt  out  128  received plaintext.
- key  out  128  received key.
- ct  out  128  received ciphertext.
- samp_we  out  1  sample write strobe.
- samp_addr  out  ADDRW  sample index.
- samp_data  out  8  sample value.
- mark_idx  out  ADDRW  index of first MARKER sample.
- mark_found  out  1  MARKER seen in this frame.
- frame_done  out  1  one-cycle pulse at frame end.
- timeout_err  out  1  sticky; set on inter-byte timeout, cleared by next accepted command.
- cmd_err  out  1  one-cycle pulse on rejected command.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE.
  - All outputs 0: pt/key/ct=0, samp_*=0, mark_*=0, tx_*=0, frame_done=0, timeout_err=0, cmd_err=0.
  - cmd_ready=1 after release.
  - Reset mid-frame abandons the frame; no frame_done.
- States: IDLE, SEND, WAIT_TX, RX_PT, RX_KEY, RX_CT, RX_SAMP, DONE.
- IDLE:
  - cmd_valid & cmd_ready with cmd_byte==250 or cmd_byte<=31 → latch tx_byte=cmd_byte, clear timeout_err, mark_found, mark_idx and byte counter, go SEND.
  - Any other value → cmd_err pulses the next cycle, stay IDLE, no tx.
  - rx_dv in IDLE is ignored.
- SEND: tx_dv=1 for exactly one cycle, go WAIT_TX.
- WAIT_TX:
  - Wait for tx_done, then go RX_PT and zero the timeout counter.
  - rx_dv in SEND/WAIT_TX is ignored.
- RX_PT/RX_KEY/RX_CT:
  - Each rx_dv shifts the byte in MSB first: the first byte lands in [127:120], the 16th in [7:0].
  - A 4-bit counter wraps at 16 and advances the state.
  - The word registers update in place; they are valid only at frame_done.
- RX_SAMP, per rx_dv:
  - samp_we=1 for one cycle; samp_addr=counter (0..SAMPLES-1); samp_data=rx_byte, registered (1-cycle latency from rx_dv).
  - If rx_byte==MARKER and !mark_found: mark_found<=1, mark_idx<=counter.
  - After index SAMPLES-1 is written, go DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- Timeout:
  - In RX_* states the counter increments each cycle and resets on rx_dv.
  - On reaching TIMEOUT-1 without rx_dv: timeout_err<=1, go IDLE, no frame_done, partial data is left as is.
  - Counter saturates and does not wrap.
- Simultaneous events:
  - rx_dv in the same cycle as the timeout terminal count: the byte wins and the counter resets.
  - cmd_valid outside IDLE is ignored; cmd_ready=0.
- Byte counter is 12 bits, enough to cover 48+SAMPLES with no overflow.

Test Plan:
- cmd_byte=250, then model returns pt=000102..0F, key=000102030405060708090a0b0c0d0ef0, ct=AA×16, samples i&8'hFF with sample 700=255 → tx_byte=250 once; pt/key/ct exact; 2048 samp_we pulses, addresses 0..2047; mark_found=1, mark_idx=700; one frame_done.
- cmd_byte=17 → tx_byte=17; full frame accepted. cmd_byte=40 → cmd_err pulse, no tx_dv, cmd_ready stays 1.
- Stop after 30 bytes and idle TIMEOUT cycles → timeout_err=1, state IDLE, no frame_done; next valid cmd clears timeout_err.
- Samples with no 255, and samples with 255 at indexes 5 and 9 → mark_found=0; then mark_idx=5.
- Assert rstn=0 during sample 1000 → all outputs 0 immediately; a following 250 command completes a clean frame.
- Stray rx_dv bytes in IDLE and WAIT_TX → ignored; pt first byte is the one after tx_done.
